// File: rtl/exe_mem_stage.sv
// EXE stage (ALU, destination select, branch resolution) plus the EXE/MEM pipeline register.
// The EXE-side destination info is also exported combinationally for hazard detection and forwarding.
module exe_mem_stage #(
    parameter int         WIDTH       = 32,
    parameter logic [3:0] BUBBLE_TYPE = 4'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic             ewmem,
    input  logic             eshift,
    input  logic             ealuimm,
    input  logic [3:0]       ealuc,
    input  logic [WIDTH-1:0] odata_a,
    input  logic [WIDTH-1:0] odata_b,
    input  logic [WIDTH-1:0] odata_imm,
    input  logic             e_branch,
    input  logic [WIDTH-1:0] e_pc4,
    input  logic             e_regrt,
    input  logic [4:0]       e_rt,
    input  logic [4:0]       e_rd,
    input  logic [3:0]       EXE_ins_type,
    input  logic [3:0]       EXE_ins_number,
    output logic             mwreg,
    output logic             mm2reg,
    output logic             mwmem,
    output logic [WIDTH-1:0] malu,
    output logic [WIDTH-1:0] mdata_b,
    output logic [4:0]       mrn,
    output logic             m_br_taken,
    output logic [WIDTH-1:0] m_br_target,
    output logic [3:0]       MEM_ins_type,
    output logic [3:0]       MEM_ins_number,
    output logic [4:0]       exe_rn,
    output logic             exe_wreg
);

    function automatic logic signed [WIDTH-1:0] alu_op(
        input logic [3:0]              op,
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        logic [4:0] sa;
        sa = a[4:0];
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~(a | b);
            4'd6:    return {{(WIDTH-1){1'b0}}, (a < b)};
            4'd7:    return {{(WIDTH-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
            4'd8:    return b << sa;
            4'd9:    return $signed($unsigned(b) >> sa);
            4'd10:   return b >>> sa;
            4'd11:   return $signed(WIDTH'({b[15:0], 16'h0000}));
            default: return '0;
        endcase
    endfunction

    logic signed [WIDTH-1:0] opa_p0;
    logic signed [WIDTH-1:0] opb_p0;
    logic signed [WIDTH-1:0] alu_p0;
    logic        [WIDTH-1:0] diff_p0;
    logic                    br_taken_p0;
    logic        [WIDTH-1:0] br_target_p0;

    // EXE stage (p0): operand select, ALU, branch resolution, destination select
    always_comb begin
        opa_p0 = eshift  ? $signed({{(WIDTH-5){1'b0}}, odata_imm[10:6]}) : $signed(odata_a);
        opb_p0 = ealuimm ? $signed(odata_imm) : $signed(odata_b);
    end

    assign alu_p0 = alu_op(ealuc, opa_p0, opb_p0);

    // The branch compare always uses the raw register operands, never the muxed ALU inputs.
    assign diff_p0      = odata_a - odata_b;
    assign br_taken_p0  = e_branch & (diff_p0 == '0);
    assign br_target_p0 = e_pc4 + (odata_imm << 2);

    assign exe_rn   = e_regrt ? e_rt : e_rd;
    assign exe_wreg = ewreg & (exe_rn != 5'd0);

    // EXE/MEM register (p1): reset > flush > stall > load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mwreg          <= 1'b0;
            mm2reg         <= 1'b0;
            mwmem          <= 1'b0;
            malu           <= '0;
            mdata_b        <= '0;
            mrn            <= 5'd0;
            m_br_taken     <= 1'b0;
            m_br_target    <= '0;
            MEM_ins_type   <= BUBBLE_TYPE;
            MEM_ins_number <= 4'd0;
        end else if (flush) begin
            mwreg          <= 1'b0;
            mm2reg         <= 1'b0;
            mwmem          <= 1'b0;
            malu           <= '0;
            mdata_b        <= '0;
            mrn            <= 5'd0;
            m_br_taken     <= 1'b0;
            m_br_target    <= '0;
            MEM_ins_type   <= BUBBLE_TYPE;
            MEM_ins_number <= 4'd0;
        end else if (!stall) begin
            mwreg          <= exe_wreg;
            mm2reg         <= em2reg;
            mwmem          <= ewmem;
            malu           <= alu_p0;
            mdata_b        <= odata_b;
            mrn            <= exe_rn;
            m_br_taken     <= br_taken_p0;
            m_br_target    <= br_target_p0;
            MEM_ins_type   <= EXE_ins_type;
            MEM_ins_number <= EXE_ins_number;
        end
    end

endmodule

// File: tb/tb_exe_mem_stage.sv
// Scoreboard bench for exe_mem_stage: directed EXE vectors push hand-computed MEM-side results,
// a monitor pops and compares one entry per clock after each edge that has one queued.
module tb_exe_mem_stage;

    localparam logic [3:0] BUB = 4'hA;

    logic        clk, rst, stall, flush;
    logic        ewreg, em2reg, ewmem, eshift, ealuimm, e_branch, e_regrt;
    logic [3:0]  ealuc, EXE_ins_type, EXE_ins_number;
    logic [31:0] odata_a, odata_b, odata_imm, e_pc4;
    logic [4:0]  e_rt, e_rd;
    logic        mwreg, mm2reg, mwmem, m_br_taken, exe_wreg;
    logic [31:0] malu, mdata_b, m_br_target;
    logic [4:0]  mrn, exe_rn;
    logic [3:0]  MEM_ins_type, MEM_ins_number;

    exe_mem_stage #(.WIDTH(32), .BUBBLE_TYPE(BUB)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
        .eshift(eshift), .ealuimm(ealuimm), .ealuc(ealuc),
        .odata_a(odata_a), .odata_b(odata_b), .odata_imm(odata_imm),
        .e_branch(e_branch), .e_pc4(e_pc4), .e_regrt(e_regrt),
        .e_rt(e_rt), .e_rd(e_rd),
        .EXE_ins_type(EXE_ins_type), .EXE_ins_number(EXE_ins_number),
        .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
        .malu(malu), .mdata_b(mdata_b), .mrn(mrn),
        .m_br_taken(m_br_taken), .m_br_target(m_br_target),
        .MEM_ins_type(MEM_ins_type), .MEM_ins_number(MEM_ins_number),
        .exe_rn(exe_rn), .exe_wreg(exe_wreg)
    );

    typedef struct packed {
        logic [7:0]  tag;
        logic        wreg, m2reg, wmem;
        logic [31:0] alu, datab;
        logic [4:0]  rn;
        logic        taken;
        logic [31:0] target;
        logic [3:0]  itype, inum;
        logic        chk_num;
    } exp_t;

    exp_t q[$];
    int   compared = 0;
    int   mismatched = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_m(input logic [7:0] tag, input logic w, input logic m2, input logic wm,
                            input logic [31:0] alu, input logic [31:0] db, input logic [4:0] rn,
                            input logic tk, input logic [31:0] tg, input logic [3:0] it,
                            input logic [3:0] in, input logic cn);
        exp_t e;
        e = '{tag: tag, wreg: w, m2reg: m2, wmem: wm, alu: alu, datab: db, rn: rn,
              taken: tk, target: tg, itype: it, inum: in, chk_num: cn};
        q.push_back(e);
    endtask

    task automatic idle();
        ewreg = 0; em2reg = 0; ewmem = 0; eshift = 0; ealuimm = 0; e_branch = 0; e_regrt = 0;
        ealuc = 0; odata_a = 0; odata_b = 0; odata_imm = 0; e_pc4 = 0; e_rt = 0; e_rd = 0;
        EXE_ins_type = 0; EXE_ins_number = 0;
    endtask

    task automatic check_all_zero(input string name);
        chk({name, ".mwreg"}, mwreg, 0);
        chk({name, ".mm2reg"}, mm2reg, 0);
        chk({name, ".mwmem"}, mwmem, 0);
        chk({name, ".malu"}, malu, 0);
        chk({name, ".mdata_b"}, mdata_b, 0);
        chk({name, ".mrn"}, mrn, 0);
        chk({name, ".m_br_taken"}, m_br_taken, 0);
        chk({name, ".m_br_target"}, m_br_target, 0);
        chk({name, ".MEM_ins_type"}, MEM_ins_type, BUB);
        chk({name, ".MEM_ins_number"}, MEM_ins_number, 0);
    endtask

    // Monitor: one queued expectation is checked shortly after each rising edge.
    initial begin
        exp_t e;
        string n;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                n = $sformatf("v%0d", e.tag);
                chk({n, ".mwreg"}, mwreg, e.wreg);
                chk({n, ".mm2reg"}, mm2reg, e.m2reg);
                chk({n, ".mwmem"}, mwmem, e.wmem);
                chk({n, ".malu"}, malu, e.alu);
                chk({n, ".mdata_b"}, mdata_b, e.datab);
                chk({n, ".mrn"}, mrn, e.rn);
                chk({n, ".m_br_taken"}, m_br_taken, e.taken);
                chk({n, ".m_br_target"}, m_br_target, e.target);
                chk({n, ".MEM_ins_type"}, MEM_ins_type, e.itype);
                if (e.chk_num) chk({n, ".MEM_ins_number"}, MEM_ins_number, e.inum);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; stall = 0; flush = 0;
        idle();
        #1;
        check_all_zero("reset");

        // ADD 5+7 -> rd 3, released from reset on the same negedge
        @(negedge clk); rst = 0; idle();
        odata_a = 5; odata_b = 7; ealuc = 0; e_rd = 3; ewreg = 1; EXE_ins_type = 1; EXE_ins_number = 1;
        expect_m(1, 1, 0, 0, 32'd12, 32'd7, 5'd3, 0, 32'h0, 4'd1, 4'd1, 1);
        #1;
        chk("add.exe_rn", exe_rn, 5'd3);
        chk("add.exe_wreg", exe_wreg, 1);

        // SRA by imm[10:6]=4; target = 0x100 << 2
        @(negedge clk); idle();
        eshift = 1; odata_imm = 32'h100; odata_b = 32'h8000_0000; ealuc = 10; e_rd = 5; ewreg = 1;
        em2reg = 1; EXE_ins_type = 2; EXE_ins_number = 2;
        expect_m(2, 1, 1, 0, 32'hF800_0000, 32'h8000_0000, 5'd5, 0, 32'h400, 4'd2, 4'd2, 1);

        // SRL, same operands
        @(negedge clk); idle();
        eshift = 1; odata_imm = 32'h100; odata_b = 32'h8000_0000; ealuc = 9; e_rd = 5; ewreg = 1;
        ewmem = 1; EXE_ins_type = 2; EXE_ins_number = 3;
        expect_m(3, 1, 0, 1, 32'h0800_0000, 32'h8000_0000, 5'd5, 0, 32'h400, 4'd2, 4'd3, 1);

        // LUI with immediate 0x1234
        @(negedge clk); idle();
        ealuimm = 1; odata_imm = 32'h1234; odata_b = 32'h11; ealuc = 11; e_regrt = 1; e_rt = 8; ewreg = 1;
        EXE_ins_type = 3; EXE_ins_number = 4;
        expect_m(4, 1, 0, 0, 32'h1234_0000, 32'h11, 5'd8, 0, 32'h48D0, 4'd3, 4'd4, 1);

        // Taken branch, then not-taken branch on the next cycle
        @(negedge clk); idle();
        e_branch = 1; odata_a = 32'h55; odata_b = 32'h55; e_pc4 = 32'h100; odata_imm = 3;
        EXE_ins_type = 4; EXE_ins_number = 5;
        expect_m(5, 0, 0, 0, 32'hAA, 32'h55, 5'd0, 1, 32'h10C, 4'd4, 4'd5, 1);
        @(negedge clk); idle();
        e_branch = 1; odata_a = 32'h55; odata_b = 32'h56; e_pc4 = 32'h100; odata_imm = 3;
        EXE_ins_type = 4; EXE_ins_number = 6;
        expect_m(6, 0, 0, 0, 32'hAB, 32'h56, 5'd0, 0, 32'h10C, 4'd4, 4'd6, 1);

        // Load ADD, then stall three cycles with different EXE inputs
        @(negedge clk); idle();
        odata_a = 5; odata_b = 7; ealuc = 0; e_rd = 3; ewreg = 1; EXE_ins_type = 1; EXE_ins_number = 7;
        expect_m(7, 1, 0, 0, 32'd12, 32'd7, 5'd3, 0, 32'h0, 4'd1, 4'd7, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle(); stall = 1;
            odata_a = 100; odata_b = 1; ealuc = 1; e_rd = 9; ewreg = 1; EXE_ins_type = 5; EXE_ins_number = 8;
            expect_m(8 + i, 1, 0, 0, 32'd12, 32'd7, 5'd3, 0, 32'h0, 4'd1, 4'd7, 1);
        end
        // stall and flush together: flush wins
        @(negedge clk); stall = 1; flush = 1;
        expect_m(11, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0, BUB, 4'd0, 0);

        // Taken branch held through a stall, then cleared by an idle load
        @(negedge clk); stall = 0; flush = 0; idle();
        e_branch = 1; odata_a = 32'h55; odata_b = 32'h55; e_pc4 = 32'h100; odata_imm = 3;
        EXE_ins_type = 4; EXE_ins_number = 9;
        expect_m(12, 0, 0, 0, 32'hAA, 32'h55, 5'd0, 1, 32'h10C, 4'd4, 4'd9, 1);
        @(negedge clk); idle(); stall = 1;
        expect_m(13, 0, 0, 0, 32'hAA, 32'h55, 5'd0, 1, 32'h10C, 4'd4, 4'd9, 1);
        @(negedge clk); idle(); stall = 0;
        expect_m(14, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0, 4'd0, 4'd0, 1);

        // SLT to r0: write suppressed; then SLTU to r9
        @(negedge clk); idle();
        odata_a = 32'hFFFF_FFFF; odata_b = 1; ealuc = 6; ewreg = 1; e_regrt = 1; e_rt = 0; e_rd = 7;
        EXE_ins_type = 6; EXE_ins_number = 10;
        expect_m(15, 0, 0, 0, 32'd1, 32'd1, 5'd0, 0, 32'h0, 4'd6, 4'd10, 1);
        #1;
        chk("r0.exe_rn", exe_rn, 5'd0);
        chk("r0.exe_wreg", exe_wreg, 0);
        @(negedge clk); idle();
        odata_a = 32'hFFFF_FFFF; odata_b = 1; ealuc = 7; ewreg = 1; e_regrt = 1; e_rt = 9; e_rd = 7;
        EXE_ins_type = 6; EXE_ins_number = 11;
        expect_m(16, 1, 0, 0, 32'd0, 32'd1, 5'd9, 0, 32'h0, 4'd6, 4'd11, 1);
        #1;
        chk("sltu.exe_rn", exe_rn, 5'd9);
        chk("sltu.exe_wreg", exe_wreg, 1);

        // Async reset mid-cycle after a taken branch, then recovery
        @(negedge clk); idle();
        e_branch = 1; odata_a = 32'h55; odata_b = 32'h55; e_pc4 = 32'h100; odata_imm = 3;
        EXE_ins_type = 4; EXE_ins_number = 12;
        expect_m(17, 0, 0, 0, 32'hAA, 32'h55, 5'd0, 1, 32'h10C, 4'd4, 4'd12, 1);
        @(posedge clk);
        #3;
        rst = 1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk); rst = 0; idle();
        odata_a = 5; odata_b = 7; ealuc = 0; e_rd = 3; ewreg = 1; EXE_ins_type = 1; EXE_ins_number = 13;
        expect_m(18, 1, 0, 0, 32'd12, 32'd7, 5'd3, 0, 32'h0, 4'd1, 4'd13, 1);
        @(negedge clk); idle();
        expect_m(19, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0, 4'd0, 4'd0, 1);

        for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk);
        #2;
        chk("drain.queue_left", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
